if_stage: RTL



---
 rtl/if_stage_pkg.sv | 9 +
 rtl/if_btb.sv | 37 +++
 rtl/if_stage.sv | 59 +++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared bus widths, reset PC default and PC helpers for the fetch stage
package if_stage_pkg;
  localparam int IF_TO_IPD_BUS_WD = 96;
  localparam int ID_TO_IF_BUS_WD = 33;
  localparam logic [31:0] RESET_PC_DEF = 32'h1C00_0000;
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction
endpackage

// File: rtl/if_btb.sv
// if_btb: direct-mapped branch target buffer with combinational lookup and clocked update
module if_btb #(
  parameter int IDX_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] lookup_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  output logic        hit,
  output logic [31:0] target
);
  localparam int N = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;
  logic [N-1:0]     valid;
  logic [TAG_W-1:0] tags [N];
  logic [31:0]      targets [N];
  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag;
  assign lk_idx  = lookup_pc[IDX_W+1:2];
  assign lk_tag  = lookup_pc[31:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  // lookup reads pre-update contents; a same-cycle write is not bypassed
  assign hit    = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign target = targets[lk_idx];
  // only valid bits need clearing on reset; tag/target are qualified by them
  always_ff @(posedge clk or posedge reset)
    if (reset) valid <= '0;
    else if (upd_valid) valid[upd_idx] <= 1'b1;
  // last write wins, aliasing entries are simply overwritten
  always_ff @(posedge clk)
    if (upd_valid) begin
      tags[upd_idx]    <= upd_pc[31:IDX_W+2];
      targets[upd_idx] <= upd_target;
    end
endmodule

// File: rtl/if_stage.sv
// if_stage: fetch PC owner, inst RAM requester and next-PC predictor
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter bit          BTB_EN    = 1'b1,
  parameter int          BTB_IDX_W = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ID_TO_IF_BUS_WD-1:0]  ID_to_IF_bus,
  input  logic                        btb_upd_valid,
  input  logic [31:0]                 btb_upd_pc,
  input  logic [31:0]                 btb_upd_target,
  output logic [IF_TO_IPD_BUS_WD-1:0] IF_to_IPD_bus,
  output logic                        IF_to_IPD_valid,
  input  logic                        IPD_allow_in,
  output logic                        inst_ram_en,
  output logic [31:0]                 inst_ram_addr
);
  logic        br_taken_cancel;
  logic [31:0] pc_from_id, pc_reg, pred_pc, btb_target;
  logic        if_valid, handshake, btb_hit;
  assign {br_taken_cancel, pc_from_id} = ID_to_IF_bus;
  generate
    if (BTB_EN) begin : g_btb
      if_btb #(.IDX_W(BTB_IDX_W)) u_btb (
        .clk       (clk),
        .reset     (reset),
        .lookup_pc (pc_reg),
        .upd_valid (btb_upd_valid),
        .upd_pc    (btb_upd_pc),
        .upd_target(btb_upd_target),
        .hit       (btb_hit),
        .target    (btb_target)
      );
    end else begin : g_no_btb
      assign btb_hit    = 1'b0;
      assign btb_target = '0;
    end
  endgenerate
  assign pred_pc         = btb_hit ? btb_target : seq_pc(pc_reg);
  assign handshake       = if_valid && IPD_allow_in && !br_taken_cancel;
  // en=0 during a stall lets the BRAM hold its output for IPD
  assign inst_ram_en     = handshake;
  assign inst_ram_addr   = pc_reg;
  assign IF_to_IPD_valid = if_valid && !br_taken_cancel;
  assign IF_to_IPD_bus   = {pred_pc, pc_reg, 32'b0};
  // redirect beats handshake; stall or idle holds the PC
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_reg   <= RESET_PC;
      if_valid <= 1'b0;
    end else begin
      if_valid <= 1'b1;
      if (br_taken_cancel) pc_reg <= pc_from_id;
      else if (handshake) pc_reg <= pred_pc;
    end
endmodule
